// File: rtl/dpram_arb.sv
`timescale 1ns/1ps
// dpram_arb: two-port RAM with same-address collision arbitration and a clear-to-zero sequencer
// Ports:
//   clk                  rising-edge clock
//   rst                  asynchronous active-low reset
//   clr                  synchronous request to re-zero the whole memory
//   req_x, we_x          port request (held until acked), 1 = write / 0 = read
//   addr_x, din_x        port address and write data
//   ack_x                combinational grant for this cycle
//   dout_x, rvalid_x     registered read data and its one-cycle valid pulse
//   ready                memory in RUN and accepting requests
//   coll_cnt             saturating count of arbitration conflicts
module dpram_arb #(
    parameter int AW   = 4,
    parameter int DW   = 8,
    parameter int PRIO = 0,
    parameter int CW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          req_a,
    input  logic          req_b,
    input  logic          we_a,
    input  logic          we_b,
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] din_a,
    input  logic [DW-1:0] din_b,
    output logic          ack_a,
    output logic          ack_b,
    output logic [DW-1:0] dout_a,
    output logic [DW-1:0] dout_b,
    output logic          rvalid_a,
    output logic          rvalid_b,
    output logic          ready,
    output logic [CW-1:0] coll_cnt
);
    localparam int DP = 2**AW;
    typedef enum logic {CLEAR, RUN} state_t;
    state_t        state;
    logic [AW-1:0] clr_ptr;
    logic          rr;
    logic          conflict;
    logic          lose_a;
    logic          lose_b;
    logic [DW-1:0] mem [DP];
    assign ready    = state == RUN;
    // Two reads of one address never conflict; any write to a shared address does.
    assign conflict = req_a & req_b & (addr_a == addr_b) & (we_a | we_b);
    // rr = 1 means B won the previous conflict is owed... i.e. B wins the next one.
    assign lose_a   = conflict & (PRIO == 1 || (PRIO == 2 && rr));
    assign lose_b   = conflict & !lose_a;
    assign ack_a    = req_a & ready & !lose_a;
    assign ack_b    = req_b & ready & !lose_b;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= CLEAR;
            clr_ptr  <= '0;
            rr       <= 1'b0;
            coll_cnt <= '0;
            dout_a   <= '0;
            dout_b   <= '0;
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
        end else begin
            if (ack_a && !we_a) dout_a <= mem[addr_a];
            if (ack_b && !we_b) dout_b <= mem[addr_b];
            // A read granted while clr is taken would pulse during CLEAR, so its valid is dropped.
            rvalid_a <= ack_a & !we_a & !clr;
            rvalid_b <= ack_b & !we_b & !clr;
            if (conflict && ready) begin
                rr <= !rr;
                if (!(&coll_cnt)) coll_cnt <= coll_cnt + 1'b1;
            end
            if (clr) begin
                state   <= CLEAR;
                clr_ptr <= '0;
            end else if (state == CLEAR) begin
                clr_ptr <= clr_ptr + 1'b1;
                if (&clr_ptr) state <= RUN;
            end
        end
    end
    // Storage has no reset: contents are only defined once the CLEAR sweep completes.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_ptr] <= '0;
        end else begin
            if (ack_a && we_a) mem[addr_a] <= din_a;
            if (ack_b && we_b) mem[addr_b] <= din_b;
        end
    end
endmodule

// File: tb/tb_dpram_arb.sv
`timescale 1ns/1ps
// tb_dpram_arb: directed scoreboard bench for dpram_arb
// Three instances share one stimulus: u0 (PRIO=0, CW=8), u2 (PRIO=2, CW=8), uc (PRIO=0, CW=2).
// Reads on u0 push the expected word from a bench-side memory model; a negedge monitor pops
// and compares whenever u0 pulses rvalid.
module tb_dpram_arb;
    logic       clk = 1'b0, rst = 1'b0, clr = 1'b0;
    logic       req_a = 1'b0, req_b = 1'b0, we_a = 1'b0, we_b = 1'b0;
    logic [3:0] addr_a = '0, addr_b = '0;
    logic [7:0] din_a = '0, din_b = '0;
    logic       ack_a, ack_b, rvalid_a, rvalid_b, ready;
    logic [7:0] dout_a, dout_b, coll_cnt;
    logic       ack_a2, ack_b2, rv_a2, rv_b2, ready2;
    logic [7:0] dout_a2, dout_b2, coll2;
    logic       ack_ac, ack_bc, rv_ac, rv_bc, readyc;
    logic [7:0] dout_ac, dout_bc;
    logic [1:0] collc;
    logic [7:0] model [16];
    logic [7:0] qa [$];
    logic [7:0] qb [$];
    int         passed = 0, total = 0;

    always #5 clk = ~clk;

    dpram_arb #(.PRIO(0)) u0 (
        .clk(clk), .rst(rst), .clr(clr), .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .din_a(din_a), .din_b(din_b), .ack_a(ack_a), .ack_b(ack_b),
        .dout_a(dout_a), .dout_b(dout_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b), .ready(ready),
        .coll_cnt(coll_cnt));
    dpram_arb #(.PRIO(2)) u2 (
        .clk(clk), .rst(rst), .clr(clr), .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .din_a(din_a), .din_b(din_b), .ack_a(ack_a2), .ack_b(ack_b2),
        .dout_a(dout_a2), .dout_b(dout_b2), .rvalid_a(rv_a2), .rvalid_b(rv_b2), .ready(ready2),
        .coll_cnt(coll2));
    dpram_arb #(.PRIO(0), .CW(2)) uc (
        .clk(clk), .rst(rst), .clr(clr), .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .din_a(din_a), .din_b(din_b), .ack_a(ack_ac), .ack_b(ack_bc),
        .dout_a(dout_ac), .dout_b(dout_bc), .rvalid_a(rv_ac), .rvalid_b(rv_bc), .ready(readyc),
        .coll_cnt(collc));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic ra, input logic wa, input logic [3:0] aa, input logic [7:0] da,
                       input logic rb, input logic wb, input logic [3:0] ab, input logic [7:0] db);
        req_a = ra; we_a = wa; addr_a = aa; din_a = da;
        req_b = rb; we_b = wb; addr_b = ab; din_b = db;
    endtask

    // Check u0 grants at the negedge and update the model with what the bench expects to be granted.
    task automatic acc(input logic ea, input logic eb);
        @(negedge clk);
        chk("ack_a", ack_a, ea);
        chk("ack_b", ack_b, eb);
        if (ea && req_a && !we_a) qa.push_back(model[addr_a]);
        if (eb && req_b && !we_b) qb.push_back(model[addr_b]);
        if (ea && req_a && we_a) model[addr_a] = din_a;
        if (eb && req_b && we_b) model[addr_b] = din_b;
    endtask

    task automatic op(input logic ra, input logic wa, input logic [3:0] aa, input logic [7:0] da,
                      input logic rb, input logic wb, input logic [3:0] ab, input logic [7:0] db,
                      input logic ea, input logic eb);
        drv(ra, wa, aa, da, rb, wb, ab, db);
        acc(ea, eb);
        tick();
    endtask

    always @(negedge clk) begin
        if (rvalid_a) begin
            if (qa.size() != 0) chk("dout_a", dout_a, qa.pop_front());
            else chk("rvalid_a_unexpected", rvalid_a, 0);
        end
        if (rvalid_b) begin
            if (qb.size() != 0) chk("dout_b", dout_b, qb.pop_front());
            else chk("rvalid_b_unexpected", rvalid_b, 0);
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) model[i] = '0;
        repeat (2) tick();
        chk("rst_ready", ready, 0);
        chk("rst_coll", coll_cnt, 0);
        chk("rst_dout_a", dout_a, 0);
        chk("rst_dout_b", dout_b, 0);
        chk("rst_rvalid_a", rvalid_a, 0);
        chk("rst_rvalid_b", rvalid_b, 0);
        rst   = 1'b1;
        req_a = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("init_ready", ready, i == 16);
            chk("init_ready2", ready2, i == 16);
            chk("init_readyc", readyc, i == 16);
            if (i < 16) chk("init_ack_a", ack_a, 0);
            if (i == 15) req_a = 1'b0;
        end
        for (int a = 0; a < 16; a++) op(1, 0, 4'(a), 0, 0, 0, 0, 0, 1, 0);
        op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        op(1, 1, 3, 8'hA5, 0, 0, 0, 0, 1, 0);
        op(0, 0, 0, 0, 1, 0, 3, 0, 0, 1);
        op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rvalid_b_pulse", rvalid_b, 0);
        op(1, 1, 6, 8'h77, 1, 0, 3, 0, 1, 1);
        op(1, 0, 6, 0, 0, 0, 0, 0, 1, 0);
        op(1, 1, 8, 8'h88, 1, 1, 9, 8'h99, 1, 1);
        op(1, 0, 8, 0, 1, 0, 9, 0, 1, 1);
        op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("coll_none", coll_cnt, 0);
        for (int k = 0; k < 3; k++) begin
            drv(1, 1, 10, 8'h31, 1, 1, 10, 8'h32);
            acc(1, 0);
            chk("rr_ack_a", ack_a2, k != 1);
            chk("rr_ack_b", ack_b2, k == 1);
            chk("cw2_ack_a", ack_ac, 1);
            tick();
            chk("coll_cnt", coll_cnt, k + 1);
            chk("coll_rr", coll2, k + 1);
            chk("coll_cw2", collc, k + 1);
        end
        drv(1, 1, 5, 8'h11, 1, 1, 5, 8'h22);
        acc(1, 0);
        chk("rr4_ack_b", ack_b2, 1);
        tick();
        chk("coll_4", coll_cnt, 4);
        chk("coll_cw2_sat", collc, 3);
        op(0, 0, 0, 0, 1, 1, 5, 8'h22, 0, 1);
        chk("coll_held", coll_cnt, 4);
        op(1, 0, 5, 0, 1, 0, 10, 0, 1, 1);
        op(1, 1, 7, 8'h7E, 0, 0, 0, 0, 1, 0);
        op(1, 0, 7, 0, 1, 0, 7, 0, 1, 1);
        chk("coll_dual_read", coll_cnt, 4);
        op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_ready", ready, 0);
        drv(1, 1, 2, 8'hAA, 1, 1, 2, 8'hBB);
        for (int i = 1; i <= 16; i++) begin
            acc(0, 0);
            tick();
            chk("clr_ready_run", ready, i == 16);
        end
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) model[i] = '0;
        chk("clr_coll_kept", coll_cnt, 4);
        chk("clr_dout_a_kept", dout_a, 8'h7E);
        chk("clr_dout_b_kept", dout_b, 8'h7E);
        op(1, 0, 7, 0, 1, 0, 10, 0, 1, 1);
        op(1, 0, 5, 0, 1, 0, 2, 0, 1, 1);
        op(1, 1, 1, 8'hC1, 1, 1, 1, 8'hC2, 1, 0);
        chk("coll_5", coll_cnt, 5);
        chk("coll_cw2_5", collc, 3);
        chk("coll_rr_5", coll2, 5);
        op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (5) tick();
        rst = 1'b0;
        #1;
        chk("async_ready", ready, 0);
        chk("async_coll", coll_cnt, 0);
        chk("async_coll_rr", coll2, 0);
        chk("async_coll_cw2", collc, 0);
        repeat (2) tick();
        rst = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("rerun_ready", ready, i == 16);
        end
        chk("post_dout_a", dout_a, 0);
        chk("post_dout_b", dout_b, 0);
        chk("post_dout_a2", dout_a2, 0);
        chk("post_dout_b2", dout_b2, 0);
        chk("post_dout_ac", dout_ac, 0);
        chk("post_dout_bc", dout_bc, 0);
        chk("post_rvalid", {rv_a2, rv_b2, rv_ac, rv_bc, rvalid_a, rvalid_b}, 0);
        chk("post_acks", {ack_ac, ack_bc}, 0);
        chk("sb_a_empty", qa.size(), 0);
        chk("sb_b_empty", qb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
